instr_fetch_stage: RTL and testbench
====================================

INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 Parameter MEM_DEPTH, default 64, instruction memory depth in 32-bit words (power of two); AW = log2(MEM_DEPTH).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 LoadInstructions  input  1  load-mode request; one instruction word written per cycle while high.
REQ-005 Instruction  input  32  instruction word to store during load.
REQ-006 Stall  input  1  hazard stall from decode; hold PC and IF/ID register.
REQ-007 Branch  input  1  redirect request; flush IF/ID and load PC from BranchTarget.
REQ-008 BranchTarget  input  32  byte address of redirect target.
REQ-009 IF_ID_Instr  output  32  fetched instruction for decode.
REQ-010 IF_ID_PCPlus4  output  32  byte address of fetched instruction plus 4.
REQ-011 IF_ID_Valid  output  1  IF/ID register holds a real instruction.
REQ-012 ProgLen  output  AW+1  number of words written by the latest load session.
REQ-013 LoadFull  output  1  high when ProgLen == MEM_DEPTH.

Function
REQ-014 FSM states IDLE, LOAD, RUN; state register updates every cycle.
REQ-015 IDLE: LoadInstructions=1 -> LOAD, writing Instruction to word 0 that cycle, ProgLen<=1; LoadInstructions=0 -> RUN.
REQ-016 LOAD: LoadInstructions=1 -> write Instruction to word ProgLen, ProgLen+1; LoadInstructions=0 -> IDLE, no write.
REQ-017 LOAD when ProgLen == MEM_DEPTH: writes ignored, ProgLen saturates, LoadFull=1; no wrap onto word 0.
REQ-018 LOAD/IDLE: PC held at 0, IF_ID_Valid=0, IF_ID_Instr=0, IF_ID_PCPlus4=0.
REQ-019 RUN: LoadInstructions ignored (no write, no state change); a new load requires Reset first.
REQ-020 RUN, no Stall, no Branch: IF_ID_Instr<=mem[PC[AW+1:2]], IF_ID_PCPlus4<=PC+4, IF_ID_Valid<=1, PC<=PC+4; one-cycle fetch latency.
REQ-021 Word index >= ProgLen: IF_ID_Instr<=0 (NOP), IF_ID_Valid<=0, PC still advances.
REQ-022 Word index uses PC bits [AW+1:2] only; PC beyond MEM_DEPTH words wraps modulo MEM_DEPTH for indexing; PC itself is full 32-bit, wraps at 2^32.
REQ-023 Stall=1, Branch=0: PC and all IF/ID outputs hold.
REQ-024 Branch=1 (priority over Stall): PC<={BranchTarget[31:2],2'b00}, IF_ID_Instr<=0, IF_ID_Valid<=0, IF_ID_PCPlus4 holds.
REQ-025 Stall and Branch ignored outside RUN.
REQ-026 Memory read is combinational from PC; memory write is synchronous.

Reset
REQ-027 Reset=1: state<=IDLE, PC<=0, IF_ID_Instr<=0, IF_ID_PCPlus4<=0, IF_ID_Valid<=0 on next edge; Reset overrides all other inputs.
REQ-028 Reset preserves memory contents and ProgLen; ProgLen changes only on entry to LOAD; value before first load is undefined.
REQ-029 Reset mid-LOAD: word presented that cycle not written; ProgLen keeps count of completed writes.
REQ-030 Reset mid-RUN: fetch restarts at PC=0 after IDLE cycle, program intact.

Structure
REQ-031 Shared package holds the FSM state enumeration, NOP constant (32'h0000_0000) and MEM_DEPTH default.
REQ-032 One sub-module instr_mem: MEM_DEPTH x 32, one synchronous write port, one combinational read port.

Verification
REQ-033 Reset 1 cycle; load 11 words starting 0x200101A7; Reset 1 cycle; release -> ProgLen=11; one IDLE cycle; first RUN edge gives IF_ID_Instr=0x200101A7, IF_ID_PCPlus4=4, IF_ID_Valid=1.
REQ-034 Run same program 12 fetches -> fetch 12 (word 11) gives IF_ID_Instr=0, IF_ID_Valid=0, IF_ID_PCPlus4=48.
REQ-035 RUN at PC=8, Stall=1 for 3 cycles -> outputs frozen at word 1 / PCPlus4=8, PC=8; after release next fetch is word 2, PCPlus4=12.
REQ-036 RUN, Branch=1 with Stall=1 and BranchTarget=0x00000013 -> next edge IF_ID_Valid=0, IF_ID_Instr=0, PC=0x10; following edge fetches word 4, PCPlus4=0x14.
REQ-037 MEM_DEPTH=64, hold LoadInstructions 70 cycles -> ProgLen=64, LoadFull=1, word 0 unchanged.
REQ-038 Reset asserted at load cycle 5 -> ProgLen=5, state IDLE, words 0-4 intact, word 5 not written.

Source files
------------

// File: rtl/instr_fetch_stage_pkg.sv
// instr_fetch_stage_pkg: shared FSM states, NOP word and default memory depth
package instr_fetch_stage_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int MEM_DEPTH_DEFAULT = 64;
endpackage

// File: rtl/instr_fetch_stage_if.sv
// instr_fetch_stage_if: load/control inputs and IF/ID outputs of the fetch stage
interface instr_fetch_stage_if import instr_fetch_stage_pkg::*; #(
  parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
);
  localparam int AW = $clog2(MEM_DEPTH);
  logic          LoadInstructions;
  logic [31:0]   Instruction;
  logic          Stall;
  logic          Branch;
  logic [31:0]   BranchTarget;
  logic [31:0]   IF_ID_Instr;
  logic [31:0]   IF_ID_PCPlus4;
  logic          IF_ID_Valid;
  logic [AW:0]   ProgLen;
  logic          LoadFull;
  modport master (
    output LoadInstructions, Instruction, Stall, Branch, BranchTarget,
    input  IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, ProgLen, LoadFull
  );
  modport slave (
    input  LoadInstructions, Instruction, Stall, Branch, BranchTarget,
    output IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, ProgLen, LoadFull
  );
endinterface

// File: rtl/instr_fetch_stage_instr_mem.sv
// instr_mem: instruction store, synchronous write port and combinational read port
module instr_mem #(
  parameter int MEM_DEPTH = 64,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [MEM_DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: loads a program into instruction memory, then fetches it into the IF/ID register
module instr_fetch_stage import instr_fetch_stage_pkg::*; #(
  parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
  input logic clk,
  input logic Reset,
  instr_fetch_stage_if.slave bus
);
  localparam int AW = $clog2(MEM_DEPTH);
  state_t      state, nxt;
  logic [31:0] pc, if_instr, if_pc4, rdata;
  logic        if_valid, full, we, hit;
  logic [AW:0] prog_len;
  logic [AW-1:0] idx, waddr;
  always_comb begin
    nxt = state == IDLE ? (bus.LoadInstructions ? LOAD : RUN) :
          state == LOAD ? (bus.LoadInstructions ? LOAD : IDLE) : RUN;
  end
  assign full  = prog_len == (AW+1)'(MEM_DEPTH);
  assign we    = !Reset && bus.LoadInstructions && (state == IDLE || (state == LOAD && !full));
  assign waddr = state == IDLE ? '0 : prog_len[AW-1:0];
  assign idx   = pc[AW+1:2];
  assign hit   = {1'b0, idx} < prog_len;
  instr_mem #(.MEM_DEPTH(MEM_DEPTH)) u_mem (
    .clk(clk), .we(we), .waddr(waddr), .wdata(bus.Instruction),
    .raddr(idx), .rdata(rdata)
  );
  // prog_len survives reset so a program can be rerun without reloading
  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= IDLE;
      pc       <= '0;
      if_instr <= NOP;
      if_pc4   <= '0;
      if_valid <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.LoadInstructions) prog_len <= (AW+1)'(1);
      else if (state == LOAD && bus.LoadInstructions && !full) prog_len <= prog_len + 1'b1;
      if (state != RUN) begin
        pc       <= '0;
        if_instr <= NOP;
        if_pc4   <= '0;
        if_valid <= 1'b0;
      end else if (bus.Branch) begin
        pc       <= bus.BranchTarget & ~32'h3;
        if_instr <= NOP;
        if_valid <= 1'b0;
      end else if (!bus.Stall) begin
        pc       <= pc + 32'd4;
        if_pc4   <= pc + 32'd4;
        if_instr <= hit ? rdata : NOP;
        if_valid <= hit;
      end
    end
  end
  assign bus.IF_ID_Instr   = if_instr;
  assign bus.IF_ID_PCPlus4 = if_pc4;
  assign bus.IF_ID_Valid   = if_valid;
  assign bus.ProgLen       = prog_len;
  assign bus.LoadFull      = full;
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: directed vectors for load, run, stall, branch and reset corner cases
module tb_instr_fetch_stage;
  import instr_fetch_stage_pkg::*;
  logic clk = 0;
  logic Reset;
  int n_cmp = 0;
  int n_bad = 0;
  instr_fetch_stage_if #(.MEM_DEPTH(64)) bus();
  instr_fetch_stage #(.MEM_DEPTH(64)) dut (.clk(clk), .Reset(Reset), .bus(bus.slave));
  always #5 clk = ~clk;

  typedef struct {
    logic ld; logic st; logic br; logic [31:0] tgt;
    logic [31:0] ei; logic [31:0] ep; logic ev;
  } vec_t;
  vec_t vt [22];

  function automatic logic [31:0] p(int i);
    return 32'h200101A7 + 32'(i) * 32'h0001_0203;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_if(string nm, logic [31:0] ei, logic [31:0] ep, logic ev);
    chk({nm, ".instr"}, bus.IF_ID_Instr, ei);
    chk({nm, ".pc4"}, bus.IF_ID_PCPlus4, ep);
    chk({nm, ".valid"}, 32'(bus.IF_ID_Valid), 32'(ev));
  endtask

  task automatic row(int k, logic ld, logic st, logic br, logic [31:0] tgt,
                     logic [31:0] ei, logic [31:0] ep, logic ev);
    vt[k] = '{ld, st, br, tgt, ei, ep, ev};
  endtask

  initial begin
    row(0,  0, 0, 0, 0,      p(0),  32'h04,  1);
    row(1,  0, 0, 0, 0,      p(1),  32'h08,  1);
    row(2,  0, 1, 0, 0,      p(1),  32'h08,  1);
    row(3,  0, 1, 0, 0,      p(1),  32'h08,  1);
    row(4,  0, 1, 0, 0,      p(1),  32'h08,  1);
    row(5,  0, 0, 0, 0,      p(2),  32'h0C,  1);
    row(6,  0, 1, 1, 32'h13, NOP,   32'h0C,  0);
    row(7,  0, 0, 0, 0,      p(4),  32'h14,  1);
    row(8,  0, 0, 0, 0,      p(5),  32'h18,  1);
    row(9,  0, 0, 0, 0,      p(6),  32'h1C,  1);
    row(10, 0, 0, 0, 0,      p(7),  32'h20,  1);
    row(11, 0, 0, 0, 0,      p(8),  32'h24,  1);
    row(12, 0, 0, 0, 0,      p(9),  32'h28,  1);
    row(13, 0, 0, 0, 0,      p(10), 32'h2C,  1);
    row(14, 0, 0, 0, 0,      NOP,   32'h30,  0);
    row(15, 0, 0, 0, 0,      NOP,   32'h34,  0);
    row(16, 0, 0, 1, 0,      NOP,   32'h34,  0);
    row(17, 0, 0, 0, 0,      p(0),  32'h04,  1);
    row(18, 0, 0, 1, 32'h102, NOP,  32'h04,  0);
    row(19, 1, 0, 0, 0,      p(0),  32'h104, 1);
    row(20, 1, 0, 1, 0,      NOP,   32'h104, 0);
    row(21, 1, 0, 0, 0,      p(0),  32'h04,  1);

    Reset = 1;
    bus.LoadInstructions = 0; bus.Instruction = 0;
    bus.Stall = 0; bus.Branch = 0; bus.BranchTarget = 0;
    tick();
    chk_if("reset", NOP, 0, 0);

    Reset = 0; bus.LoadInstructions = 1;
    for (int i = 0; i < 11; i++) begin
      bus.Instruction = p(i);
      tick();
    end
    Reset = 1; bus.LoadInstructions = 0;
    tick();
    Reset = 0;
    chk("proglen11", 32'(bus.ProgLen), 11);
    chk("loadfull11", 32'(bus.LoadFull), 0);
    tick();
    chk_if("idle", NOP, 0, 0);

    for (int k = 0; k < 22; k++) begin
      bus.LoadInstructions = vt[k].ld;
      bus.Instruction = 32'hDEADBEEF;
      bus.Stall = vt[k].st;
      bus.Branch = vt[k].br;
      bus.BranchTarget = vt[k].tgt;
      tick();
      chk_if($sformatf("vec%0d", k), vt[k].ei, vt[k].ep, vt[k].ev);
    end
    bus.LoadInstructions = 0; bus.Stall = 0; bus.Branch = 0; bus.BranchTarget = 0;

    Reset = 1;
    tick();
    chk_if("rst_run", NOP, 0, 0);
    Reset = 0;
    tick();
    chk_if("rst_idle", NOP, 0, 0);
    tick();
    chk_if("rst_refetch", p(0), 4, 1);

    Reset = 1;
    tick();
    Reset = 0; bus.LoadInstructions = 1;
    for (int i = 0; i < 70; i++) begin
      bus.Instruction = 32'hA000_0000 + 32'(i);
      tick();
    end
    chk("proglen64", 32'(bus.ProgLen), 64);
    chk("loadfull64", 32'(bus.LoadFull), 1);
    bus.LoadInstructions = 0;
    tick();
    tick();
    chk_if("full_idle", NOP, 0, 0);
    tick();
    chk_if("full_w0", 32'hA000_0000, 4, 1);
    bus.Branch = 1; bus.BranchTarget = 32'hFC;
    tick();
    bus.Branch = 0;
    tick();
    chk_if("full_w63", 32'hA000_003F, 32'h100, 1);

    Reset = 1;
    tick();
    Reset = 0; bus.LoadInstructions = 1;
    for (int i = 0; i < 5; i++) begin
      bus.Instruction = 32'hC000_0000 + 32'(i);
      tick();
    end
    bus.Instruction = 32'hC000_0005;
    Reset = 1;
    tick();
    chk("proglen5", 32'(bus.ProgLen), 5);
    chk("loadfull5", 32'(bus.LoadFull), 0);
    chk("state_idle", 32'(dut.state), 32'(IDLE));
    chk("word5_kept", dut.u_mem.mem[5], 32'hA000_0005);
    Reset = 0; bus.LoadInstructions = 0;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i < 5) chk_if($sformatf("part_w%0d", i), 32'hC000_0000 + 32'(i), 32'(4 * (i + 1)), 1);
      else chk_if("part_w5", NOP, 32'h18, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
